stereo_disparity_sad: RTL and testbench
=======================================

STEREO_DISPARITY_SAD -- requirements
Module: stereo_disparity_sad

Interface
REQ-001 Parameter WIDTH, 320, pixels per row (even, ≥ DMAX).
REQ-002 Parameter HEIGHT, 240, rows per frame.
REQ-003 Parameter DMAX, 16, disparity candidates 0..DMAX-1 (power of two, ≤ 32).
REQ-004 Parameter SCALE_SHIFT, 4, left shift applied to disparity for 8-bit output.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 HCLK  input  1  clock, all state on rising edge.
REQ-007 HRESET  input  1  asynchronous active-high reset.
REQ-008 VSYNC  input  1  high between frames; clears row/column/frame state.
REQ-009 HSYNC  input  1  beat valid: DATA_* carry two pixels this cycle.
REQ-010 DATA_0_L, DATA_1_L  input  8 each  left-image pixels at columns c and c+1 (c even).
REQ-011 DATA_0_R, DATA_1_R  input  8 each  right-image pixels at columns c and c+1.
REQ-012 DISP_VALID  output  1  DISP_0/DISP_1 valid this cycle.
REQ-013 DISP_0, DISP_1  output  8 each  scaled disparity for columns c, c+1.
REQ-014 DISP_ROW  output  9  row of current output beat; DISP_COL  output  10  column c of current output beat.
REQ-015 FRAME_DONE  output  1  one-cycle pulse on last output beat of a frame.

Function
REQ-016 Input beats arrive whenever HSYNC=1; there is no backpressure; block accepts one beat every cycle indefinitely.
REQ-017 A row is WIDTH/2 beats; column counter advances by 2 per beat, wraps to 0 after WIDTH-2 and increments row.
REQ-018 Right-pixel history holds the last DMAX right pixels of the current row, shifting by 2 per beat.
REQ-019 History entries SHALL be marked invalid at the start of each row (first beat after column wrap, or after VSYNC).
REQ-020 For left pixel at column x, cost(d) = |L[x] - R[x-d]|, 8-bit unsigned, for d = 0..DMAX-1.
REQ-021 Candidates with x-d < 0 are excluded; column 0 therefore yields disparity 0.
REQ-022 Disparity = d with minimum cost; ties resolve to smallest d.
REQ-023 Output value = min(d << SCALE_SHIFT, 255), saturating.
REQ-024 Pipeline: S1 absolute differences, S2 argmin tree levels 1-2, S3 remaining levels, S4 scale and register outputs; latency exactly 4 cycles from HSYNC beat to DISP_VALID.
REQ-025 DISP_ROW/DISP_COL travel with the data through the pipeline and equal the beat's input row/column.
REQ-026 Gaps in HSYNC (line blanking) SHALL NOT disturb in-flight beats; the pipeline advances every cycle.
REQ-027 FRAME_DONE asserts with DISP_VALID on beat (HEIGHT-1, WIDTH-2), then row counter returns to 0.
REQ-028 VSYNC=1 resets row/column counters and invalidates history; beats already in the pipeline still drain.
REQ-029 HSYNC and VSYNC both high in one cycle: VSYNC clear applies first, beat is accepted as row 0 column 0.

Reset
REQ-030 HRESET=1 immediately clears all pipeline valids, counters, history valid bits and FRAME_DONE.
REQ-031 During and after reset: DISP_VALID=0, DISP_0=DISP_1=0, DISP_ROW=0, DISP_COL=0, FRAME_DONE=0.
REQ-032 Reset mid-frame discards in-flight beats; the next accepted beat is row 0 column 0.

Structure
REQ-033 Package stereo_pkg holds WIDTH, HEIGHT, DMAX defaults, pixel width 8, disparity width log2(DMAX).
REQ-034 Sub-module disp_argmin (DMAX costs + valid mask -> index, registered mid-tree) instantiated twice, one per pixel lane.

Verification
REQ-035 Identical L and R textured images -> every DISP = 0, 38400 valid beats, one FRAME_DONE.
REQ-036 R = L shifted left by 5 columns (L[x] = R[x-5]), unique texture -> DISP = 80 for x ≥ 5.
REQ-037 Constant-gray L and R (all 128) -> all costs tie -> DISP = 0 everywhere.
REQ-038 Single beat HSYNC at t -> DISP_VALID exactly at t+4; 160-cycle blanking gaps -> no lost or duplicated beats.
REQ-039 HRESET pulsed mid-row 50 -> outputs 0 immediately; following frame row/col restart at 0, FRAME_DONE once.
REQ-040 Row start with bright right pixels from previous row end -> column 0,1 disparities unaffected (history cleared).

Source files
------------

// File: rtl/stereo_disparity_sad_pkg.sv
// stereo_pkg: shared defaults and pixel helpers for the stereo disparity matcher
package stereo_pkg;
  localparam int DEF_WIDTH = 320;
  localparam int DEF_HEIGHT = 240;
  localparam int DEF_DMAX = 16;
  localparam int PIX_W = 8;
  localparam int DEF_DISP_W = $clog2(DEF_DMAX);
  function automatic logic [PIX_W-1:0] absdiff(logic [PIX_W-1:0] a, logic [PIX_W-1:0] b);
    return a > b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/stereo_disparity_sad_argmin.sv
// disp_argmin: masked argmin over DMAX costs, ties to the lowest index.
// The first two tree levels are registered, then the remaining levels and the index.
module disp_argmin
  import stereo_pkg::*;
#(
  parameter int DMAX = DEF_DMAX,
  parameter int DW = DEF_DISP_W
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [DMAX*PIX_W-1:0] cost,
  input  logic [DMAX-1:0]       mask,
  output logic [DW-1:0]         idx
);
  localparam int G = DMAX / 4;
  typedef struct packed {
    logic v;
    logic [PIX_W-1:0] c;
    logic [DW-1:0] x;
  } node_t;
  node_t [DMAX-1:0] lf;
  node_t [G-1:0] mid, t;
  function automatic node_t pick(node_t a, node_t b);
    return (b.v && (!a.v || b.c < a.c)) ? b : a;
  endfunction
  always_comb begin
    lf = '0;
    for (int k = 0; k < DMAX; k++) lf[k] = '{v: mask[k], c: cost[k*PIX_W +: PIX_W], x: DW'(k)};
  end
  // in-place pairwise reduction; lower-index node stays on the left at every level
  always_comb begin
    t = mid;
    for (int w = G / 2; w > 0; w = w / 2)
      for (int i = 0; i < w; i++) t[i] = pick(t[2*i], t[2*i+1]);
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      mid <= '0;
      idx <= '0;
    end else begin
      for (int i = 0; i < G; i++)
        mid[i] <= pick(pick(lf[4*i], lf[4*i+1]), pick(lf[4*i+2], lf[4*i+3]));
      idx <= t[0].x;
    end
endmodule

// File: rtl/stereo_disparity_sad.sv
// stereo_disparity_sad: two-pixel-per-beat stereo matcher; absolute-difference costs
// against a per-row right-pixel history, argmin, scaled disparity out 4 cycles later.
module stereo_disparity_sad
  import stereo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int DMAX = DEF_DMAX,
  parameter int SCALE_SHIFT = 4
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       VSYNC,
  input  logic       HSYNC,
  input  logic [7:0] DATA_0_L,
  input  logic [7:0] DATA_1_L,
  input  logic [7:0] DATA_0_R,
  input  logic [7:0] DATA_1_R,
  output logic       DISP_VALID,
  output logic [7:0] DISP_0,
  output logic [7:0] DISP_1,
  output logic [8:0] DISP_ROW,
  output logic [9:0] DISP_COL,
  output logic       FRAME_DONE
);
  localparam int DW = $clog2(DMAX);
  logic [8:0] row, cur_row;
  logic [9:0] col, cur_col;
  logic [DMAX-2:0][7:0] hist;
  logic [DMAX-2:0] hist_v, hv;
  logic [DMAX:0][7:0] w;
  logic [DMAX:0] wv;
  logic [DMAX-1:0][7:0] c0, c1, s1_c0, s1_c1;
  logic [DMAX-1:0] s1_m0, s1_m1;
  logic [2:0] vld, plast;
  logic [2:0][8:0] prow;
  logic [2:0][9:0] pcol;
  logic [DW-1:0] i0, i1;
  logic row_end, last;
  function automatic logic [7:0] scale(logic [DW-1:0] d);
    logic [31:0] s;
    s = 32'(d) << SCALE_SHIFT;
    return s > 32'd255 ? 8'hff : s[7:0];
  endfunction
  // VSYNC clears ahead of a coincident beat, so that beat lands at row 0 column 0
  assign cur_row = VSYNC ? '0 : row;
  assign cur_col = VSYNC ? '0 : col;
  assign hv = (cur_col == '0) ? '0 : hist_v;
  assign row_end = cur_col == 10'(WIDTH - 2);
  assign last = row_end && cur_row == 9'(HEIGHT - 1);
  // w[k] is the right pixel at column c+1-k; lane 1 uses w[d], lane 0 uses w[d+1]
  assign w = {hist, DATA_0_R, DATA_1_R};
  assign wv = {hv, 2'b11};
  always_comb begin
    c0 = '0;
    c1 = '0;
    for (int d = 0; d < DMAX; d++) begin
      c0[d] = absdiff(DATA_0_L, w[d+1]);
      c1[d] = absdiff(DATA_1_L, w[d]);
    end
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      row <= '0;
      col <= '0;
      hist <= '0;
      hist_v <= '0;
    end else if (HSYNC) begin
      col <= row_end ? '0 : cur_col + 10'd2;
      row <= last ? '0 : row_end ? cur_row + 9'd1 : cur_row;
      hist <= {hist[DMAX-4:0], DATA_0_R, DATA_1_R};
      hist_v <= {hv[DMAX-4:0], 2'b11};
    end else if (VSYNC) begin
      row <= '0;
      col <= '0;
      hist_v <= '0;
    end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      vld <= '0;
      plast <= '0;
      prow <= '0;
      pcol <= '0;
      s1_c0 <= '0;
      s1_c1 <= '0;
      s1_m0 <= '0;
      s1_m1 <= '0;
      DISP_VALID <= 1'b0;
      DISP_0 <= '0;
      DISP_1 <= '0;
      DISP_ROW <= '0;
      DISP_COL <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      vld <= {vld[1:0], HSYNC};
      plast <= {plast[1:0], last};
      prow <= {prow[1:0], cur_row};
      pcol <= {pcol[1:0], cur_col};
      s1_c0 <= c0;
      s1_c1 <= c1;
      s1_m0 <= wv[DMAX:1];
      s1_m1 <= wv[DMAX-1:0];
      DISP_VALID <= vld[2];
      FRAME_DONE <= vld[2] && plast[2];
      if (vld[2]) begin
        DISP_0 <= scale(i0);
        DISP_1 <= scale(i1);
        DISP_ROW <= prow[2];
        DISP_COL <= pcol[2];
      end
    end
  disp_argmin #(.DMAX(DMAX), .DW(DW)) u_arg0 (
    .HCLK(HCLK), .HRESET(HRESET), .cost(s1_c0), .mask(s1_m0), .idx(i0)
  );
  disp_argmin #(.DMAX(DMAX), .DW(DW)) u_arg1 (
    .HCLK(HCLK), .HRESET(HRESET), .cost(s1_c1), .mask(s1_m1), .idx(i1)
  );
endmodule

// File: tb/tb_stereo_disparity_sad.sv
// tb_stereo_disparity_sad: random and structured images driven beat by beat, outputs
// compared against a whole-image brute-force disparity model with latency stamps.
module tb_stereo_disparity_sad;
  localparam int W = 48, H = 6, D = 16, SS = 5;
  logic HCLK = 0, HRESET = 1, VSYNC = 0, HSYNC = 0;
  logic [7:0] DATA_0_L = 0, DATA_1_L = 0, DATA_0_R = 0, DATA_1_R = 0;
  logic DISP_VALID, FRAME_DONE;
  logic [7:0] DISP_0, DISP_1;
  logic [8:0] DISP_ROW;
  logic [9:0] DISP_COL;
  typedef struct {int stamp, row, col, d0, d1, last;} exp_t;
  exp_t q[$];
  exp_t e;
  int imL [H][W];
  int imR [H][W];
  int cyc = 0, checks = 0, fails = 0, frames = 0, mr = 0, mc = 0;
  stereo_disparity_sad #(.WIDTH(W), .HEIGHT(H), .DMAX(D), .SCALE_SHIFT(SS)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_0_L(DATA_0_L), .DATA_1_L(DATA_1_L), .DATA_0_R(DATA_0_R), .DATA_1_R(DATA_1_R),
    .DISP_VALID(DISP_VALID), .DISP_0(DISP_0), .DISP_1(DISP_1),
    .DISP_ROW(DISP_ROW), .DISP_COL(DISP_COL), .FRAME_DONE(FRAME_DONE)
  );
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;
  task automatic chk(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  // minimum |L - R| over in-row candidates, lowest d wins ties, then scaled and saturated
  function automatic int disp(int r, int x);
    int best = 0, bc = 256, c;
    for (int d = 0; d < D; d++)
      if (x - d >= 0) begin
        c = imL[r][x] > imR[r][x-d] ? imL[r][x] - imR[r][x-d] : imR[r][x-d] - imL[r][x];
        if (c < bc) begin
          bc = c;
          best = d;
        end
      end
    return (best << SS) > 255 ? 255 : best << SS;
  endfunction
  task automatic fill(int kind);
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++)
        case (kind)
          0: begin imR[r][x] = $urandom_range(0, 255); imL[r][x] = imR[r][x]; end
          1: imR[r][x] = (x * 7 + r * 13 + 3) % 256;
          2: begin imL[r][x] = 128; imR[r][x] = 128; end
          3: begin imL[r][x] = $urandom_range(0, 255); imR[r][x] = $urandom_range(0, 255); end
          default: begin
            imR[r][x] = x >= W - D ? 255 : $urandom_range(0, 100);
            imL[r][x] = x < 2 ? 250 : $urandom_range(0, 100);
          end
        endcase
    if (kind == 1)
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++) imL[r][x] = x >= 5 ? imR[r][x-5] : $urandom_range(0, 255);
  endtask
  task automatic send(bit vs);
    @(posedge HCLK);
    #1;
    if (vs) begin
      mr = 0;
      mc = 0;
    end
    VSYNC = vs;
    HSYNC = 1;
    DATA_0_L = 8'(imL[mr][mc]);
    DATA_1_L = 8'(imL[mr][mc+1]);
    DATA_0_R = 8'(imR[mr][mc]);
    DATA_1_R = 8'(imR[mr][mc+1]);
    q.push_back('{cyc + 4, mr, mc, disp(mr, mc), disp(mr, mc + 1), int'(mr == H - 1 && mc == W - 2)});
    mc += 2;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask
  task automatic idle(int n, bit vs = 0);
    repeat (n) begin
      @(posedge HCLK);
      #1;
      HSYNC = 0;
      VSYNC = vs;
    end
    if (vs) begin
      mr = 0;
      mc = 0;
    end
  endtask
  task automatic frame(bit vs_first, int gap, int rowgap);
    int f0 = frames;
    for (int b = 0; b < H * W / 2; b++) begin
      send(vs_first && b == 0);
      if (gap > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, gap));
      if (rowgap > 0 && mc == 0) idle(rowgap);
    end
    idle(8);
    chk("frame_done_count", frames - f0, 1);
  endtask
  always @(negedge HCLK)
    if (!HRESET) begin
      if (DISP_VALID) begin
        chk("beat_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("latency", cyc, e.stamp);
          chk("disp_row", DISP_ROW, e.row);
          chk("disp_col", DISP_COL, e.col);
          chk("disp_0", DISP_0, e.d0);
          chk("disp_1", DISP_1, e.d1);
          chk("frame_done", FRAME_DONE, e.last);
        end
        if (FRAME_DONE) frames++;
      end else begin
        chk("frame_done_idle", FRAME_DONE, 0);
        if (q.size() > 0) begin
          chk("beat_not_late", int'(q[0].stamp > cyc), 1);
          if (q[0].stamp <= cyc) void'(q.pop_front());
        end
      end
    end
  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_valid", DISP_VALID, 0);
    chk("rst_disp0", DISP_0, 0);
    chk("rst_disp1", DISP_1, 0);
    chk("rst_row", DISP_ROW, 0);
    chk("rst_col", DISP_COL, 0);
    chk("rst_frame_done", FRAME_DONE, 0);
    HRESET = 0;
    fill(0); idle(2, 1); frame(0, 0, 0);
    fill(1); idle(1, 1); frame(0, 3, 0);
    fill(2); frame(0, 2, 0);
    fill(3); frame(0, 0, 160);
    send(0); idle(12);
    for (int i = 0; i < 7; i++) send(0);
    frame(1, 2, 0);
    fill(4); frame(0, 0, 0); frame(0, 4, 0);
    fill(3);
    for (int i = 0; i < W + 5; i++) send(0);
    #1;
    chk("valid_before_rst", DISP_VALID, 1);
    @(posedge HCLK);
    #3;
    HRESET = 1;
    HSYNC = 0;
    #1;
    chk("async_rst_valid", DISP_VALID, 0);
    chk("async_rst_disp0", DISP_0, 0);
    chk("async_rst_disp1", DISP_1, 0);
    chk("async_rst_row", DISP_ROW, 0);
    chk("async_rst_col", DISP_COL, 0);
    chk("async_rst_frame_done", FRAME_DONE, 0);
    q.delete();
    mr = 0;
    mc = 0;
    @(posedge HCLK);
    #1;
    HRESET = 0;
    frame(0, 0, 0);
    idle(5);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
